tron_move_sequencer: RTL and testbench

//  Upstream feeder of the collision grid. Holds both players' heads and directions,

---
 rtl/tron_move_sequencer_if.sv | 31 +++
 rtl/tron_move_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_tron_move_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/tron_move_sequencer_if.sv
// tron_move_sequencer_if
//   Issue bus between the move sequencer and the collision grid.
//   play_x / play_y  : head coordinates of the issued player, zero-extended to 32 bits
//   play_num         : 0 = player 0, 1 = player 1
//   super_enable     : 1-cycle issue strobe
//   game_over        : grid collision flag, returned to the sequencer
//   master : sequencer side, drives the issue fields and receives game_over.
//   slave  : grid side, receives the issue fields and drives game_over.
interface tron_move_sequencer_if;
    logic [31:0] play_x;
    logic [31:0] play_y;
    logic        play_num;
    logic        super_enable;
    logic        game_over;

    modport master (
        output play_x,
        output play_y,
        output play_num,
        output super_enable,
        input  game_over
    );

    modport slave (
        input  play_x,
        input  play_y,
        input  play_num,
        input  super_enable,
        output game_over
    );
endinterface

// File: rtl/tron_move_sequencer.sv
// tron_move_sequencer
//   Holds both players' heads and directions, advances them once every TICK_DIV clocks
//   and issues them to the collision grid as two back-to-back 1-cycle strobes
//   (player 0, then player 1). Freezes permanently once the grid reports game over.
// Ports
//   clock       : system clock, rising edge
//   reset       : asynchronous, active-low
//   start       : level; leaves IDLE while high
//   dir_p0/p1   : requested direction, 00 up, 01 right, 10 down, 11 left
//   grid        : issue bus (master side), see tron_move_sequencer_if
//   step_count  : completed steps, saturating at 16'hFFFF
//   halted      : high in the terminal HALT state
// Configuration
//   TRON_WRAP_EN defined  : moves wrap modulo 64.
//   TRON_WRAP_EN undefined: moves clamp at 0/63 (head repeats its cell).
module tron_move_sequencer #(
    parameter logic [15:0] TICK_DIV = 16'd50000,
    parameter logic [5:0]  P0_X0    = 6'd8,
    parameter logic [5:0]  P0_Y0    = 6'd32,
    parameter logic [5:0]  P1_X0    = 6'd55,
    parameter logic [5:0]  P1_Y0    = 6'd32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [1:0]                   dir_p0,
    input  logic [1:0]                   dir_p1,
    tron_move_sequencer_if.master        grid,
    output logic [15:0]                  step_count,
    output logic                         halted
);

    typedef enum logic [2:0] {StIdle, StWait, StIssue0, StIssue1, StHalt} state_e;

    localparam logic [1:0] DirUp    = 2'b00;
    localparam logic [1:0] DirRight = 2'b01;
    localparam logic [1:0] DirDown  = 2'b10;
    localparam logic [1:0] DirLeft  = 2'b11;

    state_e      state_q, state_d;
    logic [15:0] tick_q, tick_d;
    logic [5:0]  x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [1:0]  dir0_q, dir0_d, dir1_q, dir1_d;
    logic [5:0]  px_q, px_d, py_q, py_d;
    logic        pnum_q, pnum_d;
    logic        se_q, se_d;
    logic [15:0] step_count_q, step_count_d;
    logic        sample_en;
    logic [11:0] nxt0, nxt1;

    // Returns {x, y} after one move in direction dir.
    function automatic logic [11:0] step_head(input logic [5:0] x, input logic [5:0] y,
                                              input logic [1:0] dir);
        logic [5:0] nx;
        logic [5:0] ny;
        nx = x;
        ny = y;
`ifdef TRON_WRAP_EN
        unique case (dir)
            DirUp:    ny = y - 6'd1;
            DirRight: nx = x + 6'd1;
            DirDown:  ny = y + 6'd1;
            DirLeft:  nx = x - 6'd1;
            default:  ;
        endcase
`else
        unique case (dir)
            DirUp:    ny = (y == 6'd0)  ? y : y - 6'd1;
            DirRight: nx = (x == 6'd63) ? x : x + 6'd1;
            DirDown:  ny = (y == 6'd63) ? y : y + 6'd1;
            DirLeft:  nx = (x == 6'd0)  ? x : x - 6'd1;
            default:  ;
        endcase
`endif
        return {nx, ny};
    endfunction

    // Player 0 uses this cycle's latched direction so the final WAIT sample counts;
    // player 1 is advanced during ISSUE0, where sampling is frozen, so dir1_q is final.
    assign nxt0 = step_head(x0_q, y0_q, dir0_d);
    assign nxt1 = step_head(x1_q, y1_q, dir1_q);

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        x1_d         = x1_q;
        y1_d         = y1_q;
        px_d         = px_q;
        py_d         = py_q;
        pnum_d       = pnum_q;
        se_d         = 1'b0;
        step_count_d = step_count_q;

        // Direction requests are latched in IDLE/WAIT only; a 180-degree reversal is dropped.
        sample_en = (state_q == StIdle) || (state_q == StWait);
        dir0_d    = dir0_q;
        dir1_d    = dir1_q;
        if (sample_en && (dir_p0 != (dir0_q ^ 2'b10))) dir0_d = dir_p0;
        if (sample_en && (dir_p1 != (dir1_q ^ 2'b10))) dir1_d = dir_p1;

        case (state_q)
            StIdle: begin
                if (start) state_d = StWait;
            end
            StWait: begin
                if (grid.game_over) begin
                    state_d = StHalt;
                end else if (tick_q == TICK_DIV - 16'd1) begin
                    tick_d  = 16'd0;
                    state_d = StIssue0;
                    x0_d    = nxt0[11:6];
                    y0_d    = nxt0[5:0];
                    px_d    = nxt0[11:6];
                    py_d    = nxt0[5:0];
                    pnum_d  = 1'b0;
                    se_d    = 1'b1;
                end else begin
                    tick_d = tick_q + 16'd1;
                end
            end
            StIssue0: begin
                if (grid.game_over) begin
                    state_d = StHalt;
                end else begin
                    state_d = StIssue1;
                    x1_d    = nxt1[11:6];
                    y1_d    = nxt1[5:0];
                    px_d    = nxt1[11:6];
                    py_d    = nxt1[5:0];
                    pnum_d  = 1'b1;
                    se_d    = 1'b1;
                    if (step_count_q != 16'hFFFF) step_count_d = step_count_q + 16'd1;
                end
            end
            StIssue1: begin
                state_d = grid.game_over ? StHalt : StWait;
            end
            default: begin
                state_d = StHalt;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            tick_q       <= 16'd0;
            x0_q         <= P0_X0;
            y0_q         <= P0_Y0;
            x1_q         <= P1_X0;
            y1_q         <= P1_Y0;
            dir0_q       <= DirRight;
            dir1_q       <= DirLeft;
            px_q         <= 6'd0;
            py_q         <= 6'd0;
            pnum_q       <= 1'b0;
            se_q         <= 1'b0;
            step_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
            dir0_q       <= dir0_d;
            dir1_q       <= dir1_d;
            px_q         <= px_d;
            py_q         <= py_d;
            pnum_q       <= pnum_d;
            se_q         <= se_d;
            step_count_q <= step_count_d;
        end
    end

    assign grid.play_x       = {26'd0, px_q};
    assign grid.play_y       = {26'd0, py_q};
    assign grid.play_num     = pnum_q;
    assign grid.super_enable = se_q;
    assign step_count        = step_count_q;
    assign halted            = (state_q == StHalt);

endmodule

// File: tb/tb_tron_move_sequencer.sv
module tb_tron_move_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  dir_p0;
    logic [1:0]  dir_p1;
    logic [15:0] step_count;
    logic        halted;

    tron_move_sequencer_if gif ();

    tron_move_sequencer #(
        .TICK_DIV (16'd4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .dir_p0     (dir_p0),
        .dir_p1     (dir_p1),
        .grid       (gif),
        .step_count (step_count),
        .halted     (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  d0;
        logic [1:0]  d1;
        logic [5:0]  x0;
        logic [5:0]  y0;
        logic [5:0]  x1;
        logic [5:0]  y1;
        logic [15:0] sc;
    } vec_t;

    vec_t vecs [7];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits for the next strobe; leaves the bench #1 after the edge that raised it.
    task automatic wait_issue(input string name);
        bit found;
        int n;
        found = 1'b0;
        n     = 0;
        while (!found && n < 40) begin
            @(posedge clock);
            #1;
            n++;
            if (gif.super_enable === 1'b1) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: no strobe within 40 cycles", name);
        end
    endtask

    initial begin
        int          cnt;
        int          bad;
        logic [5:0]  ex;
        logic [15:0] sc_exp;

        // 00 up, 01 right, 10 down, 11 left; reversals (rows 1,3,5 for P0) are dropped.
        vecs[0] = '{2'b01, 2'b11,  6'd9, 6'd32, 6'd54, 6'd32, 16'd1};
        vecs[1] = '{2'b11, 2'b11, 6'd10, 6'd32, 6'd53, 6'd32, 16'd2};
        vecs[2] = '{2'b00, 2'b00, 6'd10, 6'd31, 6'd53, 6'd31, 16'd3};
        vecs[3] = '{2'b10, 2'b01, 6'd10, 6'd30, 6'd54, 6'd31, 16'd4};
        vecs[4] = '{2'b11, 2'b10,  6'd9, 6'd30, 6'd54, 6'd32, 16'd5};
        vecs[5] = '{2'b01, 2'b10,  6'd8, 6'd30, 6'd54, 6'd33, 16'd6};
        vecs[6] = '{2'b10, 2'b11,  6'd8, 6'd31, 6'd53, 6'd33, 16'd7};

        reset         = 1'b0;
        start         = 1'b0;
        dir_p0        = 2'b01;
        dir_p1        = 2'b11;
        gif.game_over = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_play_x", gif.play_x, 32'd0);
        chk("rst_play_y", gif.play_y, 32'd0);
        chk("rst_play_num", {31'd0, gif.play_num}, 32'd0);
        chk("rst_super_enable", {31'd0, gif.super_enable}, 32'd0);
        chk("rst_step_count", {16'd0, step_count}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);

        @(negedge clock);
        reset = 1'b1;
        // game_over must be ignored while idle
        gif.game_over = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("idle_ignores_game_over", {31'd0, halted}, 32'd0);
        gif.game_over = 1'b0;

        // Directed steps
        start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            dir_p0 = vecs[i].d0;
            dir_p1 = vecs[i].d1;
            wait_issue("step_strobe");
            chk("p0_num", {31'd0, gif.play_num}, 32'd0);
            chk("p0_x", gif.play_x, {26'd0, vecs[i].x0});
            chk("p0_y", gif.play_y, {26'd0, vecs[i].y0});
            @(posedge clock);
            #1;
            chk("p1_strobe", {31'd0, gif.super_enable}, 32'd1);
            chk("p1_num", {31'd0, gif.play_num}, 32'd1);
            chk("p1_x", gif.play_x, {26'd0, vecs[i].x1});
            chk("p1_y", gif.play_y, {26'd0, vecs[i].y1});
            chk("step_count", {16'd0, step_count}, {16'd0, vecs[i].sc});
        end

        // Strobe duty: exactly 2 of every 6 cycles; P0 moves down to (8,41), P1 left
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            #1;
            if (gif.super_enable === 1'b1) cnt++;
        end
        chk("strobe_duty_60", cnt, 32'd20);
        chk("step_count_17", {16'd0, step_count}, 32'd17);

        // Drive P0 right along row 41 into the east edge
        dir_p0 = 2'b01;
        dir_p1 = 2'b00;
        for (int k = 1; k <= 56; k++) begin
            wait_issue("edge_strobe");
            if (8 + k > 63) begin
`ifdef TRON_WRAP_EN
                ex = 6'd0;
`else
                ex = 6'd63;
`endif
            end else begin
                ex = 6'(8 + k);
            end
            chk("edge_p0_x", gif.play_x, {26'd0, ex});
            chk("edge_p0_y", gif.play_y, 32'd41);
            @(posedge clock);
            #1;
        end
        sc_exp = 16'd73;
        chk("step_count_73", {16'd0, step_count}, {16'd0, sc_exp});

        // game_over during ISSUE0 suppresses the player-1 strobe and halts
        wait_issue("go_strobe");
        gif.game_over = 1'b1;
        @(posedge clock);
        #1;
        gif.game_over = 1'b0;
        chk("halt_no_p1_strobe", {31'd0, gif.super_enable}, 32'd0);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_num_held", {31'd0, gif.play_num}, 32'd0);
        chk("halt_step_count", {16'd0, step_count}, {16'd0, sc_exp});
        cnt = 0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clock);
            #1;
            if (gif.super_enable !== 1'b0) cnt++;
            if (halted !== 1'b1) bad++;
        end
        chk("halt_strobes_1000", cnt, 32'd0);
        chk("halt_sticky_1000", bad, 32'd0);

        // Reset asserted during ISSUE1
        @(negedge clock);
        reset  = 1'b0;
        dir_p0 = 2'b01;
        dir_p1 = 2'b11;
        @(negedge clock);
        reset = 1'b1;
        wait_issue("pre_reset_strobe");
        @(posedge clock);
        #1;
        chk("issue1_before_reset", {31'd0, gif.play_num}, 32'd1);
        reset = 1'b0;
        start = 1'b0;
        #1;
        chk("midrst_play_x", gif.play_x, 32'd0);
        chk("midrst_play_y", gif.play_y, 32'd0);
        chk("midrst_play_num", {31'd0, gif.play_num}, 32'd0);
        chk("midrst_super_enable", {31'd0, gif.super_enable}, 32'd0);
        chk("midrst_step_count", {16'd0, step_count}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (gif.super_enable !== 1'b0) cnt++;
        end
        chk("idle_after_reset_strobes", cnt, 32'd0);
        chk("idle_after_reset_count", {16'd0, step_count}, 32'd0);
        start = 1'b1;
        wait_issue("restart_strobe");
        chk("restart_p0_x", gif.play_x, 32'd9);
        chk("restart_p0_y", gif.play_y, 32'd32);
        @(posedge clock);
        #1;
        chk("restart_p1_x", gif.play_x, 32'd54);
        chk("restart_step_count", {16'd0, step_count}, 32'd1);

        // Saturation: preload the counter near the top while in WAIT, then run 4 steps
        @(posedge clock);
        @(negedge clock);
        force dut.step_count_q = 16'hFFFD;
        @(posedge clock);
        @(negedge clock);
        release dut.step_count_q;
        for (int s = 1; s <= 4; s++) begin
            wait_issue("sat_strobe");
            @(posedge clock);
            #1;
            sc_exp = (s >= 2) ? 16'hFFFF : 16'hFFFE;
            chk("sat_step_count", {16'd0, step_count}, {16'd0, sc_exp});
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
